// File: rtl/fifo_drain_arb.sv
// Round-robin drain of an N_DTPS-lane FWFT FIFO bank onto one valid/ready stream.
// Each output word is tagged with its source lane; a lane may be drained in bursts of up to MAX_BURST words.
module fifo_drain_arb #(
    parameter  int unsigned N_DTPS     = 4,
    parameter  int unsigned FIFO_WIDTH = 16,
    parameter  int unsigned MAX_BURST  = 1,
    localparam int unsigned IDW        = $clog2(N_DTPS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_DTPS*FIFO_WIDTH-1:0] out_fifo,
    input  logic [N_DTPS-1:0]            is_fifo_empty,
    output logic [N_DTPS-1:0]            i_pop,
    input  logic                         i_en,
    output logic [FIFO_WIDTH-1:0]        o_data,
    output logic [IDW-1:0]               o_id,
    output logic                         o_valid,
    input  logic                         i_ready
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    logic [IDW-1:0]        last_q, last_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [FIFO_WIDTH-1:0] data_d;
    logic [IDW-1:0]        id_d;
    logic                  valid_d;

    logic [IDW-1:0]        sel;
    logic [IDW-1:0]        cand;
    logic                  found;
    logic                  stay;
    logic                  any_ready;
    logic                  load;

    // burst_q==0 only after reset, so the first search always rotates and starts at lane 0
    always_comb begin : lane_select
        stay  = (burst_q != '0) && (burst_q < BW'(MAX_BURST)) && !is_fifo_empty[last_q];
        sel   = last_q;
        cand  = last_q;
        found = 1'b0;
        if (!stay) begin
            for (int unsigned k = 1; k <= N_DTPS; k++) begin
                cand = IDW'((32'(last_q) + k) % N_DTPS);
                if (!found && !is_fifo_empty[cand]) begin
                    sel   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin : pop_ctrl
        any_ready = (~is_fifo_empty) != '0;
        load      = !rst && i_en && (!o_valid || i_ready) && any_ready;
        i_pop     = load ? (N_DTPS'(1) << sel) : '0;
    end

    always_comb begin : next_state
        last_d  = last_q;
        burst_d = burst_q;
        data_d  = o_data;
        id_d    = o_id;
        valid_d = o_valid;
        if (load) begin
            data_d  = out_fifo[32'(sel) * FIFO_WIDTH +: FIFO_WIDTH];
            id_d    = sel;
            valid_d = 1'b1;
            last_d  = sel;
            burst_d = stay ? burst_q + BW'(1) : BW'(1);
        end else if (o_valid && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            last_q  <= IDW'(N_DTPS - 1);
            burst_q <= '0;
            o_data  <= '0;
            o_id    <= '0;
            o_valid <= 1'b0;
        end else begin
            last_q  <= last_d;
            burst_q <= burst_d;
            o_data  <= data_d;
            o_id    <= id_d;
            o_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain_arb.sv
// Bench for fifo_drain_arb: two instances (MAX_BURST=1 and 3) fed by FWFT lane models,
// with expected {id,data} words queued at stimulus time and compared as the stream accepts them.
module tb_fifo_drain_arb;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic        i_ready;
    logic [63:0] out_fifo [2];
    logic [3:0]  empty_v  [2];
    logic [3:0]  pop_v    [2];
    logic [15:0] o_data_v [2];
    logic [1:0]  o_id_v   [2];
    logic        o_valid_v[2];

    logic [15:0] mem  [2][4][64];
    int unsigned head [2][4];
    int unsigned tail [2][4];

    logic [17:0] sb0[$];
    logic [17:0] sb3[$];
    logic [17:0] exp_w;
    int          tests;
    int          failed;
    int          cyc;
    int          first_c;
    int          last_c;

    fifo_drain_arb #(.N_DTPS(4), .FIFO_WIDTH(16), .MAX_BURST(1)) u_rr (
        .clk(clk), .rst(rst), .out_fifo(out_fifo[0]), .is_fifo_empty(empty_v[0]),
        .i_pop(pop_v[0]), .i_en(i_en), .o_data(o_data_v[0]), .o_id(o_id_v[0]),
        .o_valid(o_valid_v[0]), .i_ready(i_ready)
    );

    fifo_drain_arb #(.N_DTPS(4), .FIFO_WIDTH(16), .MAX_BURST(3)) u_burst (
        .clk(clk), .rst(rst), .out_fifo(out_fifo[1]), .is_fifo_empty(empty_v[1]),
        .i_pop(pop_v[1]), .i_en(i_en), .o_data(o_data_v[1]), .o_id(o_id_v[1]),
        .o_valid(o_valid_v[1]), .i_ready(i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT lane models: head word visible while non-empty, pop advances at the edge
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                out_fifo[d][k*16 +: 16] = mem[d][k][head[d][k] % 64];
                empty_v[d][k]           = (head[d][k] == tail[d][k]);
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 4; k++) begin
                if (pop_v[d][k]) head[d][k] <= head[d][k] + 1;
            end
        end
    end

    task automatic push(input int d, input int k, input logic [15:0] v);
        mem[d][k][tail[d][k] % 64] = v;
        tail[d][k] = tail[d][k] + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_en = 1'b1; i_ready = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) push(0, k, 16'h1000 + 16'(k));
        #1;
        tests++;
        if (pop_v[0] !== 4'b0000 || o_valid_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle: got pop=%b valid=%b, expected pop=0000 valid=0", pop_v[0], o_valid_v[0]);
        end
        tests++;
        if (o_data_v[0] !== 16'h0000 || o_id_v[0] !== 2'd0) begin
            failed++;
            $display("FAIL reset_regs: got data=%h id=%0d, expected data=0000 id=0", o_data_v[0], o_id_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (pop_v[0] !== 4'b0001) begin
            failed++;
            $display("FAIL reset_first_pop: got pop=%b, expected 0001", pop_v[0]);
        end
        for (int k = 0; k < 4; k++) sb0.push_back({2'(k), 16'h1000 + 16'(k)});
        cyc = 0;
        while (sb0.size() != 0 && cyc < 50) begin
            if (o_valid_v[0] && i_ready) begin
                exp_w = sb0.pop_front();
                tests++;
                if ({o_id_v[0], o_data_v[0]} !== exp_w) begin
                    failed++;
                    $display("FAIL reset_word: got id=%0d data=%h, expected id=%0d data=%h",
                             o_id_v[0], o_data_v[0], exp_w[17:16], exp_w[15:0]);
                end
            end
            @(negedge clk); cyc++;
        end
        tests++;
        if (sb0.size() != 0) begin
            failed++;
            $display("FAIL reset_timeout: got %0d words pending, expected 0", sb0.size());
            sb0.delete();
        end
    endtask

    task automatic test_round_robin();
        push(0, 0, 16'hA000); push(0, 0, 16'hA001); push(0, 1, 16'hB000); push(0, 3, 16'hD000);
        sb0.push_back({2'd0, 16'hA000}); sb0.push_back({2'd1, 16'hB000});
        sb0.push_back({2'd3, 16'hD000}); sb0.push_back({2'd0, 16'hA001});
        cyc = 0; first_c = -1; last_c = -1;
        while (sb0.size() != 0 && cyc < 50) begin
            if (o_valid_v[0] && i_ready) begin
                exp_w = sb0.pop_front();
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                tests++;
                if ({o_id_v[0], o_data_v[0]} !== exp_w) begin
                    failed++;
                    $display("FAIL rr_word: got id=%0d data=%h, expected id=%0d data=%h",
                             o_id_v[0], o_data_v[0], exp_w[17:16], exp_w[15:0]);
                end
            end
            @(negedge clk); cyc++;
        end
        tests++;
        if (sb0.size() != 0) begin
            failed++;
            $display("FAIL rr_timeout: got %0d words pending, expected 0", sb0.size());
            sb0.delete();
        end
        tests++;
        if (last_c - first_c != 3) begin
            failed++;
            $display("FAIL rr_throughput: got %0d cycles first-to-last, expected 3", last_c - first_c);
        end
        tests++;
        if (o_valid_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL rr_idle: got valid=%b, expected 0", o_valid_v[0]);
        end
    endtask

    task automatic test_burst();
        for (int j = 0; j < 5; j++) push(1, 1, 16'h3100 + 16'(j));
        push(1, 2, 16'h3200);
        sb3.push_back({2'd1, 16'h3100}); sb3.push_back({2'd1, 16'h3101});
        sb3.push_back({2'd1, 16'h3102}); sb3.push_back({2'd2, 16'h3200});
        sb3.push_back({2'd1, 16'h3103}); sb3.push_back({2'd1, 16'h3104});
        cyc = 0;
        while (sb3.size() != 0 && cyc < 50) begin
            if (o_valid_v[1] && i_ready) begin
                exp_w = sb3.pop_front();
                tests++;
                if ({o_id_v[1], o_data_v[1]} !== exp_w) begin
                    failed++;
                    $display("FAIL burst_word: got id=%0d data=%h, expected id=%0d data=%h",
                             o_id_v[1], o_data_v[1], exp_w[17:16], exp_w[15:0]);
                end
            end
            @(negedge clk); cyc++;
        end
        tests++;
        if (sb3.size() != 0) begin
            failed++;
            $display("FAIL burst_timeout: got %0d words pending, expected 0", sb3.size());
            sb3.delete();
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        push(0, 1, 16'h4001); push(0, 2, 16'h4002); push(0, 3, 16'h4003);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (o_valid_v[0] !== 1'b1 || o_data_v[0] !== 16'h4001 || o_id_v[0] !== 2'd1 || pop_v[0] !== 4'b0000) begin
                failed++;
                $display("FAIL bp_hold: got valid=%b data=%h id=%0d pop=%b, expected valid=1 data=4001 id=1 pop=0000",
                         o_valid_v[0], o_data_v[0], o_id_v[0], pop_v[0]);
            end
        end
        i_ready = 1'b1;
        #1;
        tests++;
        if (pop_v[0] !== 4'b0100) begin
            failed++;
            $display("FAIL bp_release_pop: got pop=%b, expected 0100", pop_v[0]);
        end
        sb0.push_back({2'd1, 16'h4001}); sb0.push_back({2'd2, 16'h4002}); sb0.push_back({2'd3, 16'h4003});
        cyc = 0;
        while (sb0.size() != 0 && cyc < 50) begin
            if (o_valid_v[0] && i_ready) begin
                exp_w = sb0.pop_front();
                tests++;
                if ({o_id_v[0], o_data_v[0]} !== exp_w) begin
                    failed++;
                    $display("FAIL bp_word: got id=%0d data=%h, expected id=%0d data=%h",
                             o_id_v[0], o_data_v[0], exp_w[17:16], exp_w[15:0]);
                end
            end
            @(negedge clk); cyc++;
        end
        tests++;
        if (sb0.size() != 0) begin
            failed++;
            $display("FAIL bp_timeout: got %0d words pending, expected 0", sb0.size());
            sb0.delete();
        end
    endtask

    task automatic test_sparse_wrap();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                push(0, 3, 16'h5030); push(0, 3, 16'h5031);
                sb0.push_back({2'd3, 16'h5030}); sb0.push_back({2'd3, 16'h5031});
            end else begin
                push(0, 0, 16'h5000);
                sb0.push_back({2'd0, 16'h5000});
            end
            cyc = 0;
            while (sb0.size() != 0 && cyc < 50) begin
                if (o_valid_v[0] && i_ready) begin
                    exp_w = sb0.pop_front();
                    tests++;
                    if ({o_id_v[0], o_data_v[0]} !== exp_w) begin
                        failed++;
                        $display("FAIL wrap_word: got id=%0d data=%h, expected id=%0d data=%h",
                                 o_id_v[0], o_data_v[0], exp_w[17:16], exp_w[15:0]);
                    end
                end
                @(negedge clk); cyc++;
            end
            tests++;
            if (sb0.size() != 0) begin
                failed++;
                $display("FAIL wrap_timeout: got %0d words pending, expected 0", sb0.size());
                sb0.delete();
            end
        end
    endtask

    task automatic test_enable();
        i_en = 1'b0;
        push(0, 1, 16'h7001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (pop_v[0] !== 4'b0000 || o_valid_v[0] !== 1'b0) begin
                failed++;
                $display("FAIL en_off: got pop=%b valid=%b, expected pop=0000 valid=0", pop_v[0], o_valid_v[0]);
            end
        end
        i_en = 1'b1;
        #1;
        tests++;
        if (pop_v[0] !== 4'b0010) begin
            failed++;
            $display("FAIL en_on_pop: got pop=%b, expected 0010", pop_v[0]);
        end
        sb0.push_back({2'd1, 16'h7001});
        cyc = 0;
        while (sb0.size() != 0 && cyc < 50) begin
            if (o_valid_v[0] && i_ready) begin
                exp_w = sb0.pop_front();
                tests++;
                if ({o_id_v[0], o_data_v[0]} !== exp_w) begin
                    failed++;
                    $display("FAIL en_word: got id=%0d data=%h, expected id=%0d data=%h",
                             o_id_v[0], o_data_v[0], exp_w[17:16], exp_w[15:0]);
                end
            end
            @(negedge clk); cyc++;
        end
        tests++;
        if (sb0.size() != 0) begin
            failed++;
            $display("FAIL en_timeout: got %0d words pending, expected 0", sb0.size());
            sb0.delete();
        end
    endtask

    task automatic test_async_reset();
        i_ready = 1'b0;
        push(0, 2, 16'h6002); push(0, 3, 16'h6003);
        @(negedge clk);
        tests++;
        if (o_valid_v[0] !== 1'b1 || o_id_v[0] !== 2'd2) begin
            failed++;
            $display("FAIL arst_loaded: got valid=%b id=%0d, expected valid=1 id=2", o_valid_v[0], o_id_v[0]);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (o_valid_v[0] !== 1'b0 || pop_v[0] !== 4'b0000) begin
            failed++;
            $display("FAIL arst_drop: got valid=%b pop=%b, expected valid=0 pop=0000", o_valid_v[0], pop_v[0]);
        end
        @(negedge clk);
        tests++;
        if (empty_v[0] !== 4'b0111) begin
            failed++;
            $display("FAIL arst_no_pop: got empty=%b, expected 0111", empty_v[0]);
        end
        push(0, 0, 16'h6000);
        rst = 1'b0;
        i_ready = 1'b1;
        sb0.push_back({2'd0, 16'h6000}); sb0.push_back({2'd3, 16'h6003});
        cyc = 0;
        while (sb0.size() != 0 && cyc < 50) begin
            if (o_valid_v[0] && i_ready) begin
                exp_w = sb0.pop_front();
                tests++;
                if ({o_id_v[0], o_data_v[0]} !== exp_w) begin
                    failed++;
                    $display("FAIL arst_word: got id=%0d data=%h, expected id=%0d data=%h",
                             o_id_v[0], o_data_v[0], exp_w[17:16], exp_w[15:0]);
                end
            end
            @(negedge clk); cyc++;
        end
        tests++;
        if (sb0.size() != 0) begin
            failed++;
            $display("FAIL arst_timeout: got %0d words pending, expected 0", sb0.size());
            sb0.delete();
        end
        tests++;
        if (o_valid_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL arst_idle: got valid=%b, expected 0", o_valid_v[0]);
        end
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        rst     = 1'b1;
        i_en    = 1'b1;
        i_ready = 1'b1;
        test_reset();
        test_round_robin();
        test_burst();
        test_backpressure();
        test_sparse_wrap();
        test_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
